// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, widths and arithmetic helpers for the multi-channel IIR filter
package iir_pkg;

  // Control FSM: wait for a sample, run the MAC sweep, publish the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } iir_state_e;

  // Coefficient address map: b taps start at B_BASE, a taps follow directly after them
  localparam int B_BASE = 0;

  function automatic int a_base(input int ntaps_b);
    return B_BASE + ntaps_b;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough that T full-scale products can be summed without wrap
  function automatic int acc_w(input int nb_in, input int nb_out, input int nb_coef, input int t);
    return max_i(nb_in, nb_out) + nb_coef + $clog2(t) + 1;
  endfunction

  // Half-up rounding (add half an LSB, arithmetic shift) then clamp to nb_out signed bits
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int nb_out);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (nb_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nb_out - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared multiplier, accumulator and round/saturate output stage
module iir_mac
  import iir_pkg::*;
#(
  parameter int NB_COEF = 8,
  parameter int OPW     = 8,
  parameter int ACC_W   = 20,
  parameter int FRAC    = 6,
  parameter int NB_OUT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [NB_COEF-1:0] coef,
  input  logic signed [OPW-1:0]     opnd,
  output logic signed [NB_OUT-1:0]  y_sat
);

  localparam int PW = NB_COEF + OPW;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;

  assign prod     = PW'(coef) * PW'(opnd);
  assign prod_ext = ACC_W'(prod);

  // Accumulate one product per enabled cycle; feedback terms are subtracted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  assign y_sat = NB_OUT'(round_sat(64'(acc_q), FRAC, NB_OUT));

endmodule

// File: rtl/iir_mc_filter.sv
// rtl/iir_mc_filter.sv - time-multiplexed multi-channel direct-form-I IIR filter
module iir_mc_filter
  import iir_pkg::*;
#(
  parameter int NB_IN   = 8,
  parameter int NB_OUT  = 8,
  parameter int NB_COEF = 8,
  parameter int FRAC    = 6,
  parameter int NTAPS_B = 4,
  parameter int NTAPS_A = 2,
  parameter int NCH     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NB_IN-1:0]                       in_data,
  input  logic [idx_w(NCH)-1:0]                  in_ch,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NB_OUT-1:0]                      out_data,
  output logic [idx_w(NCH)-1:0]                  out_ch,
  output logic                                   out_valid,
  input  logic                                   coef_we,
  input  logic [idx_w(NTAPS_B+NTAPS_A)-1:0]      coef_addr,
  input  logic [NB_COEF-1:0]                     coef_wdata,
  output logic                                   coef_err,
  input  logic                                   flush
);

  localparam int T      = NTAPS_B + NTAPS_A;
  localparam int CH_W   = idx_w(NCH);
  localparam int AW     = idx_w(T);
  localparam int OPW    = max_i(NB_IN, NB_OUT);
  localparam int ACC_W  = acc_w(NB_IN, NB_OUT, NB_COEF, T);
  localparam int A_BASE = a_base(NTAPS_B);
  localparam int NXH    = NTAPS_B - 1;

  iir_state_e st_q, st_d;
  logic                     rdy_q;
  logic [AW-1:0]            idx_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [NB_IN-1:0]  x_q;
  logic signed [NB_COEF-1:0] coef_q [T];
  logic signed [NB_IN-1:0]  xh_q [NCH][NXH];
  logic signed [NB_OUT-1:0] yh_q [NCH][NTAPS_A];

  logic                     accept, ch_ok, start, addr_ok, coef_ok;
  logic signed [OPW-1:0]    opnd;
  logic signed [NB_COEF-1:0] csel;
  logic                     sub;
  logic signed [NB_OUT-1:0] y_sat;

  // Out-of-range channels are still accepted, they just never start a MAC sweep
  assign accept  = (st_q == ST_IDLE) && rdy_q && in_valid;
  assign ch_ok   = ({1'b0, in_ch} < (CH_W+1)'(NCH));
  assign start   = accept && ch_ok;
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(T));
  assign coef_ok = coef_we && (st_q == ST_IDLE) && addr_ok;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // Next-state and handshake decode; flush aborts any sweep in progress
  always_comb begin
    st_d     = st_q;
    in_ready = 1'b0;
    case (st_q)
      ST_IDLE: begin
        in_ready = rdy_q;
        if (start) st_d = ST_MAC;
      end
      ST_MAC: begin
        if (flush)                    st_d = ST_IDLE;
        else if (idx_q == AW'(T - 1)) st_d = ST_OUT;
      end
      ST_OUT:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Holds in_ready low for the first cycle after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // Capture the accepted sample/channel and step the tap index through the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      ch_q  <= '0;
      idx_q <= '0;
    end else if (start) begin
      x_q   <= in_data;
      ch_q  <= in_ch;
      idx_q <= '0;
    end else if (st_q == ST_MAC) begin
      idx_q <= idx_q + AW'(1);
    end
  end

  // Select the coefficient and operand for the current tap: b taps first, then a taps
  always_comb begin
    opnd = OPW'(x_q);
    csel = coef_q[0];
    sub  = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (idx_q == AW'(k)) csel = coef_q[k];
    end
    for (int k = 1; k < NTAPS_B; k++) begin
      if (idx_q == AW'(k)) opnd = OPW'(xh_q[ch_q][k-1]);
    end
    for (int k = 0; k < NTAPS_A; k++) begin
      if (idx_q == AW'(A_BASE + k)) begin
        opnd = OPW'(yh_q[ch_q][k]);
        sub  = 1'b1;
      end
    end
  end

  iir_mac #(
    .NB_COEF (NB_COEF),
    .OPW     (OPW),
    .ACC_W   (ACC_W),
    .FRAC    (FRAC),
    .NB_OUT  (NB_OUT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    ((st_q == ST_MAC) && !flush),
    .sub   (sub),
    .coef  (csel),
    .opnd  (opnd),
    .y_sat (y_sat)
  );

  // Coefficient bank: resets to passthrough, writable only while idle; flush leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < T; k++) coef_q[k] <= '0;
      coef_q[B_BASE] <= NB_COEF'(2 ** FRAC);
    end else if (coef_ok) begin
      for (int k = 0; k < T; k++) begin
        if (coef_addr == AW'(k)) coef_q[k] <= coef_wdata;
      end
    end
  end

  // Per-channel delay lines: shift the finished channel on OUT, clear everything on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NXH; k++)     xh_q[c][k] <= '0;
        for (int k = 0; k < NTAPS_A; k++) yh_q[c][k] <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NXH; k++)     xh_q[c][k] <= '0;
        for (int k = 0; k < NTAPS_A; k++) yh_q[c][k] <= '0;
      end
    end else if (st_q == ST_OUT) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CH_W'(c)) begin
          xh_q[c][0] <= x_q;
          for (int k = 1; k < NXH; k++)     xh_q[c][k] <= xh_q[c][k-1];
          yh_q[c][0] <= y_sat;
          for (int k = 1; k < NTAPS_A; k++) yh_q[c][k] <= yh_q[c][k-1];
        end
      end
    end
  end

  // Registered result and error pulses; out_data/out_ch hold between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      coef_err  <= 1'b0;
    end else begin
      out_valid <= (st_q == ST_OUT) && !flush;
      coef_err  <= coef_we && !coef_ok;
      if ((st_q == ST_OUT) && !flush) begin
        out_data <= y_sat;
        out_ch   <= ch_q;
      end
    end
  end

endmodule
